axis_raw_pattern_gen: RTL

AXIS_RAW_PATTERN_GEN -- requirements
Module: axis_raw_pattern_gen

---
 rtl/axis_raw_pattern_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/axis_raw_pattern_gen.sv
// axis_raw_pattern_gen: raw Bayer test-pattern source on AXI4-Stream video (tuser = SOF, tlast = EOL).
// Ports: aclk/areset (synchronous, active-high); enable, pattern_sel, defect_en, defect_period, hblank and
//   vblank are frame controls captured at SOF; m_axis_* carries pixels; frame_cnt counts completed frames; busy = not IDLE.
// Latency: first beat one cycle after enable is seen in IDLE; under backpressure tvalid holds with a frozen payload.

module axis_raw_pattern_gen #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960,
  parameter int BAYER  = 0
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            enable,
  input  logic [1:0]      pattern_sel,
  input  logic            defect_en,
  input  logic [15:0]     defect_period,
  input  logic [11:0]     hblank,
  input  logic [15:0]     vblank,
  output logic [BITS-1:0] m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  output logic            m_axis_tuser,
  output logic [15:0]     frame_cnt,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  localparam logic [11:0]     X_LAST   = 12'(WIDTH - 1);
  localparam logic [11:0]     Y_LAST   = 12'(HEIGHT - 1);
  localparam logic [BITS-1:0] MID      = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] ALL_ONES = {BITS{1'b1}};
  localparam logic [BITS-1:0] ZERO     = {BITS{1'b0}};

  state_t      state;
  logic [11:0] x, y;            // coordinate of the beat on the outputs (next line start while in HBLANK)
  logic [15:0] blank_cnt;
  logic [15:0] dcnt;            // interior pixels generated since SOF / last injection
  logic [1:0]  sel_q;
  logic        den_q;
  logic [15:0] dper_q;
  logic [11:0] hb_q;
  logic [15:0] vb_q;

  logic            xfer, eol, eof, load, new_frame, interior, hit;
  logic [11:0]     gx, gy;
  logic [1:0]      g_sel, fmt;
  logic            g_den;
  logic [15:0]     g_dper, g_fcnt, dcnt_base, dcnt_next;
  logic [BITS-1:0] base, g_dat;

  // Pixels are generated one beat ahead: (gx, gy) is the beat loaded into the output registers at this edge.
  always_comb begin
    xfer = m_axis_tvalid && m_axis_tready;
    eol  = (x == X_LAST);
    eof  = eol && (y == Y_LAST);

    gx = '0;
    gy = '0;
    if (state == ACTIVE) begin
      if (!eol) begin
        gx = x + 12'd1;
        gy = y;
      end else if (!eof) begin
        gy = y + 12'd1;
      end
    end else if (state == HBLANK) begin
      gx = x;
      gy = y;
    end
    new_frame = (gx == '0) && (gy == '0);

    // A new frame uses the live controls; they are captured at the same edge for the rest of the frame.
    g_sel  = new_frame ? pattern_sel   : sel_q;
    g_den  = new_frame ? defect_en     : den_q;
    g_dper = new_frame ? defect_period : dper_q;
    // Back-to-back frames: frame_cnt increments on the same edge the next SOF is generated.
    g_fcnt = (state == ACTIVE && eof) ? frame_cnt + 16'd1 : frame_cnt;
    dcnt_base = new_frame ? 16'd0 : dcnt;

    fmt = 2'(BAYER) ^ {gy[0], gx[0]};
    unique case (g_sel)
      2'd0:    base = MID;
      2'd1:    base = BITS'(gx);
      2'd2:    base = (fmt == 2'd0) ? ALL_ONES : ((fmt == 2'd3) ? ZERO : MID);
      default: base = BITS'(gx) + BITS'(gy) + BITS'(g_fcnt);
    endcase

    interior = (gx >= 12'd2) && (int'(gx) <= WIDTH - 3) &&
               (gy >= 12'd2) && (int'(gy) <= HEIGHT - 3);
    hit = interior && g_den && (g_dper != 16'd0) && (dcnt_base == g_dper - 16'd1);
    g_dat = hit ? ALL_ONES : base;
    if (!interior)  dcnt_next = dcnt_base;
    else if (hit)   dcnt_next = 16'd0;
    else            dcnt_next = dcnt_base + 16'd1;

    load = 1'b0;
    unique case (state)
      IDLE:    load = enable;
      ACTIVE:  load = xfer && (!eol || (!eof && hb_q == '0) || (eof && vb_q == '0 && enable));
      HBLANK:  load = (blank_cnt == '0);
      VBLANK:  load = (blank_cnt == '0) && enable;
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tdata  <= '0;
      x             <= '0;
      y             <= '0;
      frame_cnt     <= '0;
      dcnt          <= '0;
      blank_cnt     <= '0;
      sel_q         <= '0;
      den_q         <= 1'b0;
      dper_q        <= '0;
      hb_q          <= '0;
      vb_q          <= '0;
    end else begin
      if (xfer && eof) frame_cnt <= frame_cnt + 16'd1;

      if (load) begin
        state         <= ACTIVE;
        busy          <= 1'b1;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= g_dat;
        m_axis_tuser  <= new_frame;
        m_axis_tlast  <= (gx == X_LAST);
        x             <= gx;
        y             <= gy;
        dcnt          <= dcnt_next;
        if (new_frame) begin
          sel_q  <= pattern_sel;
          den_q  <= defect_en;
          dper_q <= defect_period;
          hb_q   <= hblank;
          vb_q   <= vblank;
        end
      end else begin
        unique case (state)
          IDLE: begin
          end
          ACTIVE: begin
            if (xfer && eol) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tuser  <= 1'b0;
              x             <= gx;
              y             <= gy;
              if (!eof) begin
                state     <= HBLANK;
                blank_cnt <= {4'd0, hb_q} - 16'd1;
              end else if (vb_q != '0) begin
                state     <= VBLANK;
                blank_cnt <= vb_q - 16'd1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          HBLANK: blank_cnt <= blank_cnt - 16'd1;
          VBLANK: begin
            if (blank_cnt != '0) begin
              blank_cnt <= blank_cnt - 16'd1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
